// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES-128 encrypt block through external round stages
//
// Owns the 128-bit state register and broadcasts it on state_bus. It strobes one
// stage at a time (issue cycle), waits for that stage's valid_out (wait phase) and
// captures the stage result into the state register. A stage that stays silent for
// TIMEOUT wait cycles sends the sequencer to ERR.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start, abort         block start (IDLE/ERR only), synchronous return to IDLE
//   data_in              plaintext, latched on an accepted start
//   state_bus            state register, shared data input of every stage
//   *_valid_in           one-cycle issue strobes to subByte/shiftRow/mixColumns/addRoundKey
//   *_valid_out/*_data_out  stage result handshake and data
//   rk_idx               round-key index for the addRoundKey stage
//   busy, done, err      block in flight, one-cycle completion pulse, stage timeout
//   data_out             ciphertext (same as the state register)
module aes_round_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] state_bus,
    output logic                  sb_valid_in,
    output logic                  sr_valid_in,
    output logic                  mc_valid_in,
    output logic                  ark_valid_in,
    input  logic                  sb_valid_out,
    input  logic                  sr_valid_out,
    input  logic                  mc_valid_out,
    input  logic                  ark_valid_out,
    input  logic [DATA_WIDTH-1:0] sb_data_out,
    input  logic [DATA_WIDTH-1:0] sr_data_out,
    input  logic [DATA_WIDTH-1:0] mc_data_out,
    input  logic [DATA_WIDTH-1:0] ark_data_out,
    output logic [3:0]            rk_idx,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARK0  = 3'd1;
    localparam logic [2:0] S_SUB   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_MIX   = 3'd4;
    localparam logic [2:0] S_ARK   = 3'd5;
    localparam logic [2:0] S_FIN   = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

    logic [2:0]            fsm_q, fsm_d;
    logic                  wph_q, wph_d;
    logic [DATA_WIDTH-1:0] st_q, st_d;
    logic [3:0]            round_q, round_d;
    logic [7:0]            wcnt_q, wcnt_d;

    logic                  stage_act, is_ark, more_rnds, rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [2:0]            fsm_nxt;
    logic [3:0]            rnd_nxt;
    logic [7:0]            wcnt_inc;

    assign is_ark    = (fsm_q == S_ARK0) || (fsm_q == S_ARK);
    assign stage_act = is_ark || (fsm_q == S_SUB) || (fsm_q == S_SHIFT) || (fsm_q == S_MIX);
    assign more_rnds = round_q < LAST_RND;
    assign wcnt_inc  = wcnt_q + 8'd1;

    // Only the stage owned by the current state may complete it.
    assign rsp_vld  = (fsm_q == S_SUB)   ? sb_valid_out :
                      (fsm_q == S_SHIFT) ? sr_valid_out :
                      (fsm_q == S_MIX)   ? mc_valid_out :
                      is_ark             ? ark_valid_out : 1'b0;
    assign rsp_data = (fsm_q == S_SUB)   ? sb_data_out :
                      (fsm_q == S_SHIFT) ? sr_data_out :
                      (fsm_q == S_MIX)   ? mc_data_out : ark_data_out;

    // The final round skips mixColumns; the last addRoundKey finishes the block.
    assign fsm_nxt = (fsm_q == S_ARK0)  ? S_SUB :
                     (fsm_q == S_SUB)   ? S_SHIFT :
                     (fsm_q == S_SHIFT) ? (more_rnds ? S_MIX : S_ARK) :
                     (fsm_q == S_MIX)   ? S_ARK :
                     (more_rnds ? S_SUB : S_FIN);
    assign rnd_nxt = ((fsm_q == S_ARK0) || ((fsm_q == S_ARK) && more_rnds)) ? round_q + 4'd1 : round_q;

    always_comb begin
        fsm_d   = fsm_q;
        wph_d   = wph_q;
        st_d    = st_q;
        round_d = round_q;
        wcnt_d  = wcnt_q;
        if (abort) begin
            fsm_d = S_IDLE;
            wph_d = 1'b0;
        end else if ((fsm_q == S_IDLE) || (fsm_q == S_ERR)) begin
            if (start) begin
                fsm_d   = S_ARK0;
                wph_d   = 1'b0;
                st_d    = data_in;
                round_d = 4'd0;
                wcnt_d  = 8'd0;
            end
        end else if (fsm_q == S_FIN) begin
            fsm_d = S_IDLE;
        end else if (!wph_q) begin
            // Issue cycle: a valid_out seen here is ignored.
            wph_d  = 1'b1;
            wcnt_d = 8'd0;
        end else if (rsp_vld) begin
            fsm_d   = fsm_nxt;
            wph_d   = 1'b0;
            st_d    = rsp_data;
            round_d = rnd_nxt;
        end else begin
            wcnt_d = wcnt_inc;
            if (wcnt_inc == WAIT_MAX) begin
                fsm_d = S_ERR;
                wph_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= S_IDLE;
            wph_q   <= 1'b0;
            st_q    <= '0;
            round_q <= 4'd0;
            wcnt_q  <= 8'd0;
        end else begin
            fsm_q   <= fsm_d;
            wph_q   <= wph_d;
            st_q    <= st_d;
            round_q <= round_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign state_bus    = st_q;
    assign data_out     = st_q;
    assign rk_idx       = round_q;
    assign sb_valid_in  = (fsm_q == S_SUB) && !wph_q;
    assign sr_valid_in  = (fsm_q == S_SHIFT) && !wph_q;
    assign mc_valid_in  = (fsm_q == S_MIX) && !wph_q;
    assign ark_valid_in = is_ark && !wph_q;
    assign busy         = stage_act;
    assign done         = fsm_q == S_FIN;
    assign err          = fsm_q == S_ERR;
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Sequencer for one AES-128 encrypt block through the external round stages: subByte, shiftRow, mixColumns and addRoundKey. It owns the 128-bit state register and broadcasts it to all stages. It strobes one stage at a time and captures that stage's result on its valid_out. It also indexes the round-key store and reports completion or a stage timeout.

Parameters:
DATA_WIDTH, 128, width of the state block.
NUM_ROUNDS, 10, number of AES rounds; must be 2..15.
TIMEOUT, 16, maximum cycles to wait for a stage valid_out before error; must be 2..255.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
start  in  1  begin a block; sampled only in IDLE or ERR.
abort  in  1  synchronous return to IDLE from any state.
data_in  in  DATA_WIDTH  plaintext, latched on an accepted start.
state_bus  out  DATA_WIDTH  current state register, driven to all stage data inputs.
sb_valid_in / sr_valid_in / mc_valid_in / ark_valid_in  out  1 each  one-cycle issue strobes.
sb_valid_out / sr_valid_out / mc_valid_out / ark_valid_out  in  1 each  stage result valid.
sb_data_out / sr_data_out / mc_data_out / ark_data_out  in  DATA_WIDTH each  stage results.
rk_idx  out  4  round-key index for the addRoundKey key input.
busy  out  1  high from an accepted start until done, ERR or abort.
done  out  1  one-cycle pulse; data_out valid in that cycle.
data_out  out  DATA_WIDTH  ciphertext, equal to the state register.
err  out  1  stage timeout flag.

Behaviour:
- Reset (rst=0, async): FSM=IDLE; state register, data_out, rk_idx, round counter and wait counter = 0; every strobe, busy, done and err = 0.
- FSM states: IDLE, ARK0, SUB, SHIFT, MIX, ARK, FIN, ERR.
- Each stage state has two phases:
  - Issue: one cycle, the matching *_valid_in = 1.
  - Wait: strobe = 0; hold until the matching *_valid_out = 1.
- On the edge where the matching valid_out is seen: capture its data_out into the state register and enter the next state's issue phase.
- Valid_out of non-selected stages is ignored. Valid_out seen during the issue cycle itself is also ignored, so stages need latency of at least 1.
- Transition sequence:
  - IDLE + start: latch data_in, round = 0, busy = 1, go to ARK0 with rk_idx = 0.
  - ARK0 -> SUB with round = 1.
  - SUB -> SHIFT.
  - SHIFT -> MIX when round < NUM_ROUNDS; SHIFT -> ARK when round = NUM_ROUNDS (final round skips mixColumns).
  - MIX -> ARK.
  - ARK -> SUB with round+1 when round < NUM_ROUNDS; ARK -> FIN otherwise.
  - FIN: one cycle, done = 1, busy = 0, then IDLE.
- rk_idx = round counter, and it is stable throughout ARK/ARK0.
- data_out follows the state register and keeps its last value in IDLE.
- Latency: with latency-1 stages each step takes 2 cycles. For NUM_ROUNDS=10 that is 2 + 9×8 + 6 = 80 cycles from the start-sample edge to the FIN entry edge, so done is high in cycle 81.
- Timeout:
  - The wait counter clears on issue and increments each wait cycle.
  - If it reaches TIMEOUT with no matching valid_out: go to ERR, err = 1, busy = 0, all strobes 0.
  - ERR holds until start (clears err, behaves as an IDLE start) or abort (clears err, goes to IDLE).
- start while busy: ignored, with no effect on the state register.
- abort has priority over a stage response and over start in the same cycle. It goes to IDLE next edge, busy = 0, no done pulse, err = 0, and the state register is retained.
- Reset mid-block: immediately returns all outputs to reset values. No done pulse follows reset.

Test Plan:
- FIPS-197 C.1 through latency-1 reference stages: key 000102…0f, data_in 00112233445566778899aabbccddeeff -> done pulse at cycle 81 with data_out 69c4e0d86a7b0430d8cdb78070b4c55a. busy high cycles 1–80. Exactly 10 sb strobes, 10 sr strobes, 9 mc strobes and 11 ark strobes; rk_idx sequence 0..10.
- Stage latency 3 on mixColumns only -> same ciphertext, done at cycle 81 + 9×2 = 99.
- sr_valid_out held low in round 4 -> err = 1 exactly TIMEOUT=16 wait cycles after the sr issue, busy = 0, no done. A following start reruns the vector correctly.
- Assert abort in round 5 SUB wait coincident with sb_valid_out -> IDLE next edge, no done, busy = 0, state not overwritten by the sb data.
- start pulsed again at cycle 30 with different data -> ignored; original ciphertext still produced at cycle 81.
- rst asserted low asynchronously mid-round 3 -> all outputs 0 immediately. After release, IDLE with start=0 stays idle, no strobes.
